spi_reg_bank: RTL and testbench

Parametrised SPI Mode-0 peripheral that exposes a bank of NUM_REGS configuration registers, each DATA_W bits wide, to an external controller. It adds register readback over CIPO, strict frame-length checking and a write-strobe output. It sits between the chip's SPI pins and the PWM/output-enable logic, and drives the register contents out as one flat bus.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sync.sv | 44 ++++
 rtl/spi_reg_bank.sv | 179 +++++++++++++++++
 tb/tb_spi_reg_bank.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_pkg : shared FSM type, frame-width helper and constants for           |
// |           spi_reg_bank.  Rev 1.0                                           |
// +----------------------------------------------------------------------------+
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    OVR  = 2'd3
  } spi_state_e;

  localparam logic RW_WRITE    = 1'b1;
  localparam int   SYNC_STAGES = 2;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_sync : multi-stage synchroniser plus registered edge detector.         |
// |            level/rise/fall are time-aligned.  Rev 1.0                      |
// +----------------------------------------------------------------------------+
module spi_sync
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      dly_q  <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & dly_q;
    end
  end

  // dly_q carries the same pin-to-output delay as the edge pulses
  assign level = dly_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_reg_bank : SPI mode-0 register bank with strict frame checking.        |
// |                Optional CIPO readback via SPI_READBACK_EN.  Rev 1.0        |
// +----------------------------------------------------------------------------+
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SCLK,
  input  logic                       COPI,
  input  logic                       nCS,
  output logic                       CIPO,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr
);

  localparam int               FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int               CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_W + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic ncs_level,  ncs_rise,  ncs_fall;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_in(SCLK),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync #(.RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .async_in(COPI),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .async_in(nCS),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  spi_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [FRAME_W-1:0]  shift_q;
  logic [FRAME_W-1:0]  shift_d;
  logic                wr_strobe_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic                w_sclk_rise;
  logic [ADDR_W-1:0]   w_frame_addr;
  logic [DATA_W-1:0]   w_frame_data;
  logic                w_frame_rw;
  logic                w_commit;

  // nCS rising edge takes priority over any SCLK edge in the same cycle
  assign w_sclk_rise  = sclk_rise & ~ncs_rise;
  assign shift_d      = {shift_q[FRAME_W-2:0], copi_level};
  assign cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  assign w_frame_rw   = shift_q[FRAME_W-1];
  assign w_frame_addr = shift_q[DATA_W +: ADDR_W];
  assign w_frame_data = shift_q[DATA_W-1:0];
  assign w_commit     = ncs_rise && (state_q == DATA) && (cnt_q == CNT_W'(FRAME_W)) &&
                        (w_frame_rw == RW_WRITE) && (32'(w_frame_addr) < NUM_REGS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (ncs_rise) begin
        state_q <= IDLE;
        if (w_commit) begin
          wr_strobe_q <= 1'b1;
          wr_addr_q   <= w_frame_addr;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (ncs_fall) begin
              state_q <= CMD;
              cnt_q   <= '0;
              shift_q <= '0;
            end
          end
          CMD: begin
            if (w_sclk_rise) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_d;
              if (cnt_q == CNT_W'(ADDR_W)) state_q <= DATA;
            end
          end
          DATA: begin
            if (w_sclk_rise) begin
              cnt_q <= cnt_d;
              if (cnt_q == CNT_W'(FRAME_W)) state_q <= OVR;
              else                          shift_q <= shift_d;
            end
          end
          OVR: begin
            state_q <= OVR;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else if (w_commit) begin
      for (int r = 0; r < NUM_REGS; r++)
        if (32'(w_frame_addr) == 32'(r)) regs_q[r] <= w_frame_data;
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
    assign regs_flat[r*DATA_W +: DATA_W] = regs_q[r];
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] sout_q;
  logic [DATA_W-1:0] rd_val;
  logic              cipo_q;
  logic              w_sclk_fall;
  logic              w_cmd_done;

  assign w_sclk_fall = sclk_fall & ~ncs_rise;
  assign w_cmd_done  = (state_q == CMD) && w_sclk_rise && (cnt_q == CNT_W'(ADDR_W));

  // Address is taken from the shift value being captured this cycle
  always_comb begin
    rd_val = '0;
    for (int r = 0; r < NUM_REGS; r++)
      if (32'(shift_d[ADDR_W-1:0]) == 32'(r)) rd_val = regs_q[r];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sout_q <= '0;
      cipo_q <= 1'b0;
    end else if (ncs_rise || ncs_fall) begin
      sout_q <= '0;
      cipo_q <= 1'b0;
    end else if (w_cmd_done) begin
      sout_q <= (shift_d[ADDR_W] == RW_WRITE) ? '0 : rd_val;
    end else if ((state_q == DATA) && w_sclk_fall) begin
      cipo_q <= sout_q[DATA_W-1];
      sout_q <= {sout_q[DATA_W-2:0], 1'b0};
    end
  end

  assign CIPO = cipo_q;

  logic unused_sync;
  assign unused_sync = ^{sclk_level, copi_rise, copi_fall, ncs_level};
`else
  assign CIPO = 1'b0;

  logic unused_sync;
  assign unused_sync = ^{sclk_level, sclk_fall, copi_rise, copi_fall, ncs_level};
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_reg_bank : self-checking bench with a register-level model.         |
// |                   Rev 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_spi_reg_bank;

  localparam int NUM_REGS = 5;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int FRAME_W  = 1 + ADDR_W + DATA_W;
  localparam int HALF     = 6;

  logic                       clk   = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       SCLK  = 1'b0;
  logic                       COPI  = 1'b0;
  logic                       nCS   = 1'b1;
  logic                       CIPO;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic                       wr_strobe;
  logic [ADDR_W-1:0]          wr_addr;

  int n_cmp = 0;
  int n_err = 0;
  int strobe_cycles = 0;

  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic [ADDR_W-1:0] m_wr_addr;

  spi_reg_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(nCS),
    .CIPO(CIPO), .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_strobe === 1'b1) strobe_cycles++;

  // ---------------- reference model ----------------
  function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    for (int r = 0; r < NUM_REGS; r++) f[r*DATA_W +: DATA_W] = m_regs[r];
    return f;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) m_regs[r] = '0;
    m_wr_addr = '0;
  endtask

  task automatic model_frame(input logic [15:0] fr, input int len, output bit commit);
    int a;
    a = int'(fr[14:8]);
    commit = (len == FRAME_W) && fr[15] && (a < NUM_REGS);
    if (commit) begin
      m_regs[a] = fr[7:0];
      m_wr_addr = fr[14:8];
    end
  endtask

  // CIPO bits the controller should capture across a full frame
  function automatic logic [15:0] model_rx(input logic [15:0] fr);
    int a;
    logic [7:0] d;
    a = int'(fr[14:8]);
    d = 8'h00;
`ifdef SPI_READBACK_EN
    if (!fr[15] && a < NUM_REGS) d = m_regs[a];
`endif
    return {8'h00, d};
  endfunction

  // ---------------- SPI controller ----------------
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_begin();
    nCS = 1'b0;
    clks(HALF);
  endtask

  task automatic spi_bit(input logic b, output logic sampled);
    COPI = b;
    clks(HALF);
    sampled = CIPO;
    SCLK = 1'b1;
    clks(HALF);
    SCLK = 1'b0;
  endtask

  task automatic spi_end();
    clks(HALF);
    nCS = 1'b1;
    COPI = 1'b0;
    clks(8);
  endtask

  task automatic spi_xfer(input logic [15:0] fr, input int len, output logic [15:0] rx);
    logic s;
    logic b;
    rx = '0;
    spi_begin();
    for (int i = 0; i < len; i++) begin
      b = (i < 16) ? fr[15-i] : 1'b0;
      spi_bit(b, s);
      if (i < 16) rx[15-i] = s;
    end
    spi_end();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clks(4);
    rst_n = 1'b1;
    model_reset();
    clks(4);
    n_cmp++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL reset_regs: got %h want %h", regs_flat, model_flat()); end
    n_cmp++; if (CIPO !== 1'b0) begin n_err++; $display("FAIL reset_cipo: got %b want 0", CIPO); end
    n_cmp++; if (wr_strobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %b want 0", wr_strobe); end
    n_cmp++; if (wr_addr !== 7'd0) begin n_err++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
  endtask

  task automatic test_write();
    logic [15:0] rx;
    bit c;
    int s0;
    s0 = strobe_cycles;
    spi_xfer(16'h82A5, 16, rx);
    model_frame(16'h82A5, 16, c);
    n_cmp++; if (regs_flat[23:16] !== 8'hA5) begin n_err++; $display("FAIL write_reg2: got %h want a5", regs_flat[23:16]); end
    n_cmp++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL write_regs: got %h want %h", regs_flat, model_flat()); end
    n_cmp++; if (strobe_cycles - s0 !== 1) begin n_err++; $display("FAIL write_strobe: got %0d want 1", strobe_cycles - s0); end
    n_cmp++; if (wr_addr !== 7'd2) begin n_err++; $display("FAIL write_wr_addr: got %0d want 2", wr_addr); end
  endtask

  task automatic test_readback();
    logic [15:0] rx;
    bit c;
    int s0;
    spi_xfer(16'h813C, 16, rx);
    model_frame(16'h813C, 16, c);
    s0 = strobe_cycles;
    spi_xfer(16'h0100, 16, rx);
    n_cmp++; if (rx !== model_rx(16'h0100)) begin n_err++; $display("FAIL read_cipo: got %h want %h", rx, model_rx(16'h0100)); end
    model_frame(16'h0100, 16, c);
    n_cmp++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL read_regs: got %h want %h", regs_flat, model_flat()); end
    n_cmp++; if (strobe_cycles - s0 !== 0) begin n_err++; $display("FAIL read_strobe: got %0d want 0", strobe_cycles - s0); end
    n_cmp++; if (CIPO !== 1'b0) begin n_err++; $display("FAIL read_cipo_idle: got %b want 0", CIPO); end
  endtask

  task automatic test_frame_length();
    logic [15:0] rx;
    bit c;
    int s0;
    s0 = strobe_cycles;
    spi_xfer(16'h80FF, 15, rx);
    model_frame(16'h80FF, 15, c);
    spi_xfer(16'h80FF, 17, rx);
    model_frame(16'h80FF, 17, c);
    n_cmp++; if (regs_flat[7:0] !== 8'h00) begin n_err++; $display("FAIL len_reg0: got %h want 00", regs_flat[7:0]); end
    n_cmp++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL len_regs: got %h want %h", regs_flat, model_flat()); end
    n_cmp++; if (strobe_cycles - s0 !== 0) begin n_err++; $display("FAIL len_strobe: got %0d want 0", strobe_cycles - s0); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] rx;
    bit c;
    int s0;
    s0 = strobe_cycles;
    spi_xfer(16'h85FF, 16, rx);
    model_frame(16'h85FF, 16, c);
    spi_xfer(16'hFFFF, 16, rx);
    model_frame(16'hFFFF, 16, c);
    n_cmp++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL oor_regs: got %h want %h", regs_flat, model_flat()); end
    n_cmp++; if (strobe_cycles - s0 !== 0) begin n_err++; $display("FAIL oor_strobe: got %0d want 0", strobe_cycles - s0); end
    spi_xfer(16'h0500, 16, rx);
    n_cmp++; if (rx !== 16'h0000) begin n_err++; $display("FAIL oor_read: got %h want 0000", rx); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] rx;
    logic [15:0] fr;
    logic s;
    bit c;
    int s0;
    fr = 16'h8311;
    spi_begin();
    for (int i = 0; i < 10; i++) spi_bit(fr[15-i], s);
    rst_n = 1'b0;
    clks(1);
    rst_n = 1'b1;
    model_reset();
    clks(2);
    n_cmp++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL midrst_regs: got %h want %h", regs_flat, model_flat()); end
    n_cmp++; if (wr_addr !== 7'd0) begin n_err++; $display("FAIL midrst_wr_addr: got %0d want 0", wr_addr); end
    s0 = strobe_cycles;
    spi_end();
    spi_xfer(16'h8322, 16, rx);
    model_frame(16'h8322, 16, c);
    n_cmp++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL midrst_after: got %h want %h", regs_flat, model_flat()); end
    n_cmp++; if (regs_flat[31:24] !== 8'h22) begin n_err++; $display("FAIL midrst_reg3: got %h want 22", regs_flat[31:24]); end
    n_cmp++; if (strobe_cycles - s0 !== 1) begin n_err++; $display("FAIL midrst_strobe: got %0d want 1", strobe_cycles - s0); end
  endtask

  task automatic test_random();
    logic [15:0] rx;
    logic [15:0] fr;
    logic [15:0] exp_rx;
    logic [6:0]  a;
    bit c;
    int len;
    int s0;
    for (int it = 0; it < 30; it++) begin
      a = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
      fr = {1'($urandom_range(0, 1)), a, 8'($urandom)};
      case ($urandom_range(0, 4))
        0:       len = 15;
        1:       len = 17;
        default: len = 16;
      endcase
      exp_rx = model_rx(fr);
      s0 = strobe_cycles;
      spi_xfer(fr, len, rx);
      model_frame(fr, len, c);
      n_cmp++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL rand_regs[%0d] fr=%h len=%0d: got %h want %h", it, fr, len, regs_flat, model_flat()); end
      n_cmp++; if (strobe_cycles - s0 !== (c ? 1 : 0)) begin n_err++; $display("FAIL rand_strobe[%0d] fr=%h len=%0d: got %0d want %0d", it, fr, len, strobe_cycles - s0, c ? 1 : 0); end
      n_cmp++; if (wr_addr !== m_wr_addr) begin n_err++; $display("FAIL rand_wr_addr[%0d]: got %0d want %0d", it, wr_addr, m_wr_addr); end
      if (len >= FRAME_W) begin
        n_cmp++; if (rx !== exp_rx) begin n_err++; $display("FAIL rand_cipo[%0d] fr=%h: got %h want %h", it, fr, rx, exp_rx); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_frame_length();
    test_out_of_range();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
